// File: rtl/udma_extper_cfg_seq.sv
// udma_extper_cfg_seq
// Shares the uDMA external-peripheral channel config port between NREQ requesters.
// A round-robin winner's descriptor is written as SADDR/SIZE/CFG. The channel CFG
// register is then polled until the channel is idle, and done is pulsed to the winner.
// Optional macro UDMA_EXTPER_SEQ_TIMEOUT_EN bounds the polling. On timeout the
// channel is cleared and req_err_o is pulsed instead of req_done_o.
module udma_extper_cfg_seq #(
    parameter int NREQ           = 4,
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int POLL_GAP       = 4,
    parameter int TIMEOUT_W      = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NREQ-1:0]                  req_valid_i,
    input  logic [NREQ-1:0]                  req_dir_i,
    input  logic [NREQ*L2_AWIDTH_NOAL-1:0]   req_addr_i,
    input  logic [NREQ*TRANS_SIZE-1:0]       req_size_i,
    input  logic [NREQ*2-1:0]                req_dsize_i,
    output logic [NREQ-1:0]                  req_ready_o,
    output logic [NREQ-1:0]                  req_done_o,
    output logic [NREQ-1:0]                  req_err_o,
    output logic                             busy_o,
    output logic [31:0]                      cfg_data_o,
    output logic [4:0]                       cfg_addr_o,
    output logic                             cfg_valid_o,
    output logic                             cfg_rwn_o,
    input  logic [31:0]                      cfg_data_i,
    input  logic                             cfg_ready_i
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = IDXW + 1;
    localparam int GAPW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAPW-1:0] GAP_LAST = GAPW'(POLL_GAP - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [3:0] {
        IDLE, WR_SADDR, WR_SIZE, WR_CFG, GAP, POLL, DONE, WR_CLR, ERR
    } state_t;

    state_t                    state;
    state_t                    bus_next;
    logic [IDXW-1:0]           rr_ptr;
    logic [IDXW-1:0]           pick_idx;
    logic [CW-1:0]             cand;
    logic [IDXW-1:0]           g_idx;
    logic                      g_dir;
    logic [L2_AWIDTH_NOAL-1:0] g_addr;
    logic [TRANS_SIZE-1:0]     g_size;
    logic [1:0]                g_dsize;
    logic [GAPW-1:0]           gap_cnt;
    logic [4:0]                base;
    logic [4:0]                bus_addr;
    logic [31:0]               bus_data;
    logic                      bus_rwn;
    logic                      tmo_sat;
    logic                      unused_cfg_bits;

    assign unused_cfg_bits = ^{cfg_data_i[31:6], cfg_data_i[3:0]};
    assign base = {2'b00, g_dir, 2'b00};

    // Round-robin pick: the lowest offset from rr_ptr with a valid request wins
    always_comb begin
        pick_idx = '0;
        cand     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + CW'(i);
            if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
            if (req_valid_i[cand[IDXW-1:0]]) pick_idx = cand[IDXW-1:0];
        end
    end

    // Bus transaction that the current state issues, and where a completed write leads
    always_comb begin
        bus_addr = base + 5'd2;
        bus_data = '0;
        bus_rwn  = 1'b0;
        bus_next = IDLE;
        case (state)
            WR_SADDR: begin bus_addr = base;        bus_data = 32'(g_addr); bus_next = WR_SIZE; end
            WR_SIZE:  begin bus_addr = base + 5'd1; bus_data = 32'(g_size); bus_next = WR_CFG;  end
            WR_CFG:   begin bus_data = {27'd0, 1'b1, 1'b0, g_dsize, 1'b0}; bus_next = GAP;     end
            WR_CLR:   begin bus_data = 32'h20;      bus_next = ERR;                             end
            POLL:     begin bus_rwn = 1'b1;         bus_next = GAP;                             end
            default:  ;
        endcase
    end

`ifdef UDMA_EXTPER_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;
    assign tmo_sat = &tmo_cnt;

    // Timeout counter: restarts when CFG is written and saturates while waiting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            tmo_cnt <= '0;
        else if (state == WR_CFG && cfg_valid_o && cfg_ready_i)
            tmo_cnt <= '0;
        else if ((state == GAP || state == POLL) && !tmo_sat)
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
    end
`else
    assign tmo_sat   = 1'b0;
    assign req_err_o = '0;
`endif

    // Main sequencer: grant, descriptor writes, status polling and completion pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            g_idx       <= '0;
            g_dir       <= 1'b0;
            g_addr      <= '0;
            g_size      <= '0;
            g_dsize     <= '0;
            gap_cnt     <= '0;
            req_ready_o <= '0;
            req_done_o  <= '0;
`ifdef UDMA_EXTPER_SEQ_TIMEOUT_EN
            req_err_o   <= '0;
`endif
            busy_o      <= 1'b0;
            cfg_valid_o <= 1'b0;
            cfg_addr_o  <= '0;
            cfg_data_o  <= '0;
            cfg_rwn_o   <= 1'b0;
        end else begin
            req_ready_o <= '0;
            req_done_o  <= '0;
`ifdef UDMA_EXTPER_SEQ_TIMEOUT_EN
            req_err_o   <= '0;
`endif
            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        g_idx       <= pick_idx;
                        g_dir       <= req_dir_i[pick_idx];
                        g_addr      <= req_addr_i[pick_idx*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
                        g_size      <= req_size_i[pick_idx*TRANS_SIZE +: TRANS_SIZE];
                        g_dsize     <= req_dsize_i[pick_idx*2 +: 2];
                        req_ready_o <= ONE_HOT0 << pick_idx;
                        rr_ptr      <= (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + IDXW'(1);
                        busy_o      <= 1'b1;
                        state       <= WR_SADDR;
                    end
                end
                WR_SADDR, WR_SIZE, WR_CFG, WR_CLR, POLL: begin
                    if (!cfg_valid_o) begin
                        if (state == POLL && tmo_sat) begin
                            state <= WR_CLR;
                        end else begin
                            cfg_valid_o <= 1'b1;
                            cfg_addr_o  <= bus_addr;
                            cfg_data_o  <= bus_data;
                            cfg_rwn_o   <= bus_rwn;
                        end
                    end else if (cfg_ready_i) begin
                        cfg_valid_o <= 1'b0;
                        cfg_rwn_o   <= 1'b0;
                        if (state == POLL) begin
                            if (!cfg_data_i[4] && !cfg_data_i[5]) state <= DONE;
                            else if (tmo_sat)                     state <= WR_CLR;
                            else                                  state <= GAP;
                        end else begin
                            state <= bus_next;
                        end
                    end
                end
                GAP: begin
                    if (tmo_sat) begin
                        gap_cnt <= '0;
                        state   <= WR_CLR;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= POLL;
                    end else begin
                        gap_cnt <= gap_cnt + GAPW'(1);
                    end
                end
                DONE: begin
                    req_done_o <= ONE_HOT0 << g_idx;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
                ERR: begin
`ifdef UDMA_EXTPER_SEQ_TIMEOUT_EN
                    req_err_o <= ONE_HOT0 << g_idx;
`endif
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udma_extper_cfg_seq.sv
// Directed testbench for udma_extper_cfg_seq.
// Covers single RX and TX sequences, round-robin order, a stalled bus slave and
// reset mid-sequence. When UDMA_EXTPER_SEQ_TIMEOUT_EN is defined it also covers
// the poll timeout.
module tb_udma_extper_cfg_seq;

    localparam int NREQ = 4;
    localparam int AW   = 12;
    localparam int TS   = 16;
    localparam int PG   = 4;
    localparam int TW   = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ-1:0]      req_dir_i;
    logic [NREQ*AW-1:0]   req_addr_i;
    logic [NREQ*TS-1:0]   req_size_i;
    logic [NREQ*2-1:0]    req_dsize_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ-1:0]      req_done_o;
    logic [NREQ-1:0]      req_err_o;
    logic                 busy_o;
    logic [31:0]          cfg_data_o;
    logic [4:0]           cfg_addr_o;
    logic                 cfg_valid_o;
    logic                 cfg_rwn_o;
    logic [31:0]          cfg_data_i;
    logic                 cfg_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Bus log and event counters, written only by the monitor processes
    logic [4:0]  log_addr [256];
    logic [31:0] log_data [256];
    logic        log_rwn  [256];
    int          log_n       = 0;
    int          done_n      = 0;
    int          err_n       = 0;
    int          gap_viol    = 0;
    int          reads_total = 0;
    logic        prev_hs     = 1'b0;

    // Status model, controlled from the stimulus block
    int          read_base  = 0;
    int          busy_reads = 0;
    logic [4:0]  want_addr  = '0;

    udma_extper_cfg_seq #(
        .NREQ(NREQ), .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .POLL_GAP(PG), .TIMEOUT_W(TW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_dir_i(req_dir_i), .req_addr_i(req_addr_i),
        .req_size_i(req_size_i), .req_dsize_i(req_dsize_i),
        .req_ready_o(req_ready_o), .req_done_o(req_done_o), .req_err_o(req_err_o),
        .busy_o(busy_o), .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o),
        .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o),
        .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Channel status: en=1 for the first busy_reads polls of a test, then idle
    assign cfg_data_i = (cfg_rwn_o && ((reads_total - read_base) < busy_reads)) ? 32'h10 : 32'h0;

    // Count completed reads so the status model advances once per poll
    always @(posedge clk_i) begin
        if (cfg_valid_o && cfg_ready_i && cfg_rwn_o) reads_total <= reads_total + 1;
    end

    // Log bus handshakes and pulses mid-cycle
    always @(negedge clk_i) begin
        if (cfg_valid_o && cfg_ready_i) begin
            log_addr[log_n & 255] = cfg_addr_o;
            log_data[log_n & 255] = cfg_data_o;
            log_rwn[log_n & 255]  = cfg_rwn_o;
            log_n++;
        end
        if (prev_hs && cfg_valid_o) gap_viol++;
        prev_hs = cfg_valid_o && cfg_ready_i;
        if (req_done_o != '0) done_n++;
        if (req_err_o != '0)  err_n++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic dir, input logic [AW-1:0] addr,
                                 input logic [TS-1:0] size, input logic [1:0] dsize);
        req_dir_i[idx]            = dir;
        req_addr_i[idx*AW +: AW]  = addr;
        req_size_i[idx*TS +: TS]  = size;
        req_dsize_i[idx*2 +: 2]   = dsize;
        req_valid_i[idx]          = 1'b1;
    endtask

    function automatic logic hit(input int sel);
        case (sel)
            0:       return |req_ready_o;
            1:       return |req_done_o;
            2:       return |req_err_o;
            default: return cfg_valid_o && !cfg_rwn_o && (cfg_addr_o == want_addr);
        endcase
    endfunction

    task automatic waitSignal(input string tag, input int sel, input int budget);
        int k;
        k = 0;
        while (k < budget && !hit(sel)) begin
            tick();
            k++;
        end
        checkOutput({tag, " in time"}, 32'(k < budget), 32'd1);
    endtask

    task automatic checkLog(input string tag, input int idx, input logic rwn,
                            input logic [4:0] addr, input logic [31:0] data);
        checkOutput({tag, " rwn"}, 32'(log_rwn[idx & 255]), 32'(rwn));
        checkOutput({tag, " addr"}, 32'(log_addr[idx & 255]), 32'(addr));
        if (!rwn) checkOutput({tag, " data"}, log_data[idx & 255], data);
    endtask

    initial begin
        int lb;
        int db;
        int prev_done;

        req_valid_i = '0;
        req_dir_i   = '0;
        req_addr_i  = '0;
        req_size_i  = '0;
        req_dsize_i = '0;
        cfg_ready_i = 1'b1;
        rst_i       = 1'b1;
        repeat (3) tick();

        // Reset state
        checkOutput("rst busy", 32'(busy_o), 0);
        checkOutput("rst valid", 32'(cfg_valid_o), 0);
        checkOutput("rst rwn", 32'(cfg_rwn_o), 0);
        checkOutput("rst addr", 32'(cfg_addr_o), 0);
        checkOutput("rst data", cfg_data_o, 0);
        checkOutput("rst ready", 32'(req_ready_o), 0);
        checkOutput("rst done", 32'(req_done_o), 0);
        rst_i = 1'b0;
        tick();

        // Single RX request from requester 0, channel busy for two polls
        $display("[TB] single RX request");
        lb = log_n;
        read_base  = reads_total;
        busy_reads = 2;
        applyStimulus(0, 1'b0, 12'h123, 16'h0040, 2'd2);
        waitSignal("t1 grant", 0, 20);
        checkOutput("t1 ready vec", 32'(req_ready_o), 32'h1);
        checkOutput("t1 grant no bus req", 32'(cfg_valid_o), 0);
        checkOutput("t1 busy", 32'(busy_o), 1);
        req_valid_i[0] = 1'b0;
        waitSignal("t1 done", 1, 200);
        checkOutput("t1 done vec", 32'(req_done_o), 32'h1);
        checkOutput("t1 busy low", 32'(busy_o), 0);
        tick();
        checkOutput("t1 done one cycle", 32'(req_done_o), 0);
        checkOutput("t1 txn count", 32'(log_n - lb), 6);
        checkLog("t1 saddr", lb + 0, 1'b0, 5'd0, 32'h123);
        checkLog("t1 size",  lb + 1, 1'b0, 5'd1, 32'h40);
        checkLog("t1 cfg",   lb + 2, 1'b0, 5'd2, 32'h14);
        checkLog("t1 poll0", lb + 3, 1'b1, 5'd2, 32'h0);
        checkLog("t1 poll1", lb + 4, 1'b1, 5'd2, 32'h0);
        checkLog("t1 poll2", lb + 5, 1'b1, 5'd2, 32'h0);

        // TX request from requester 2 uses the TX register bank
        $display("[TB] TX request");
        lb = log_n;
        read_base  = reads_total;
        busy_reads = 0;
        applyStimulus(2, 1'b1, 12'h0AB, 16'h0010, 2'd1);
        waitSignal("t2 grant", 0, 20);
        checkOutput("t2 ready vec", 32'(req_ready_o), 32'h4);
        req_valid_i[2] = 1'b0;
        waitSignal("t2 done", 1, 200);
        checkOutput("t2 done vec", 32'(req_done_o), 32'h4);
        tick();
        checkOutput("t2 txn count", 32'(log_n - lb), 4);
        checkLog("t2 saddr", lb + 0, 1'b0, 5'd4, 32'hAB);
        checkLog("t2 size",  lb + 1, 1'b0, 5'd5, 32'h10);
        checkLog("t2 cfg",   lb + 2, 1'b0, 5'd6, 32'h12);
        checkLog("t2 poll",  lb + 3, 1'b1, 5'd6, 32'h0);

        // All requesters valid from reset: strict round-robin order
        $display("[TB] round-robin");
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        read_base  = reads_total;
        busy_reads = 0;
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b0, AW'(i), 16'h0004, 2'd0);
        prev_done = done_n;
        for (int k = 0; k < 5; k++) begin
            waitSignal($sformatf("t3 grant%0d", k), 0, 100);
            checkOutput($sformatf("t3 grant%0d vec", k), 32'(req_ready_o), 32'h1 << (k % 4));
            if (k > 0) checkOutput($sformatf("t3 dones before grant%0d", k), 32'(done_n - prev_done), 1);
            prev_done = done_n;
            if (k == 4) req_valid_i = '0;
            tick();
        end
        waitSignal("t3 last done", 1, 200);
        checkOutput("t3 last done vec", 32'(req_done_o), 32'h1);
        tick();

        // Slave stalls the SIZE write for three cycles
        $display("[TB] stalled SIZE write");
        lb = log_n;
        read_base  = reads_total;
        busy_reads = 0;
        applyStimulus(1, 1'b0, 12'h055, 16'h000C, 2'd0);
        waitSignal("t4 grant", 0, 20);
        checkOutput("t4 ready vec", 32'(req_ready_o), 32'h2);
        req_valid_i[1] = 1'b0;
        want_addr = 5'd1;
        waitSignal("t4 size req", 3, 20);
        cfg_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("t4 hold%0d valid", c), 32'(cfg_valid_o), 1);
            checkOutput($sformatf("t4 hold%0d addr", c), 32'(cfg_addr_o), 1);
            checkOutput($sformatf("t4 hold%0d data", c), cfg_data_o, 32'hC);
        end
        cfg_ready_i = 1'b1;
        tick();
        checkOutput("t4 valid drops", 32'(cfg_valid_o), 0);
        waitSignal("t4 done", 1, 200);
        checkOutput("t4 done vec", 32'(req_done_o), 32'h2);
        tick();
        checkOutput("t4 txn count", 32'(log_n - lb), 4);
        checkLog("t4 saddr", lb + 0, 1'b0, 5'd0, 32'h55);
        checkLog("t4 size",  lb + 1, 1'b0, 5'd1, 32'hC);
        checkLog("t4 cfg",   lb + 2, 1'b0, 5'd2, 32'h10);
        checkLog("t4 poll",  lb + 3, 1'b1, 5'd2, 32'h0);

        // Reset during GAP aborts silently; the next request starts from SADDR
        $display("[TB] reset during GAP");
        read_base  = reads_total;
        busy_reads = 5;
        applyStimulus(3, 1'b1, 12'h3FF, 16'h0200, 2'd3);
        waitSignal("t5 grant", 0, 20);
        checkOutput("t5 ready vec", 32'(req_ready_o), 32'h8);
        want_addr = 5'd6;
        waitSignal("t5 cfg req", 3, 20);
        tick();
        tick();
        db = done_n;
        rst_i = 1'b1;
        #1;
        checkOutput("t5 async busy", 32'(busy_o), 0);
        checkOutput("t5 async valid", 32'(cfg_valid_o), 0);
        tick();
        checkOutput("t5 rst busy", 32'(busy_o), 0);
        checkOutput("t5 rst valid", 32'(cfg_valid_o), 0);
        checkOutput("t5 rst data", cfg_data_o, 0);
        checkOutput("t5 no done", 32'(done_n - db), 0);
        lb = log_n;
        read_base  = reads_total;
        busy_reads = 0;
        applyStimulus(3, 1'b1, 12'h010, 16'h0000, 2'd0);
        rst_i = 1'b0;
        waitSignal("t5 regrant", 0, 20);
        checkOutput("t5 regrant vec", 32'(req_ready_o), 32'h8);
        req_valid_i[3] = 1'b0;
        waitSignal("t5 done", 1, 200);
        checkOutput("t5 done vec", 32'(req_done_o), 32'h8);
        tick();
        checkOutput("t5 txn count", 32'(log_n - lb), 4);
        checkLog("t5 saddr", lb + 0, 1'b0, 5'd4, 32'h10);
        checkLog("t5 size0", lb + 1, 1'b0, 5'd5, 32'h0);
        checkLog("t5 cfg",   lb + 2, 1'b0, 5'd6, 32'h10);
        checkLog("t5 poll",  lb + 3, 1'b1, 5'd6, 32'h0);

`ifdef UDMA_EXTPER_SEQ_TIMEOUT_EN
        // Channel never goes idle: timeout clears it and reports an error
        $display("[TB] poll timeout");
        db = done_n;
        read_base  = reads_total;
        busy_reads = 100000;
        applyStimulus(0, 1'b0, 12'h001, 16'h0004, 2'd1);
        waitSignal("t6 grant", 0, 20);
        req_valid_i[0] = 1'b0;
        waitSignal("t6 err", 2, 300);
        checkOutput("t6 err vec", 32'(req_err_o), 32'h1);
        checkOutput("t6 no done", 32'(done_n - db), 0);
        checkLog("t6 clr", log_n - 1, 1'b0, 5'd2, 32'h20);
        tick();
        checkOutput("t6 busy low", 32'(busy_o), 0);
        checkOutput("t6 err one cycle", 32'(req_err_o), 0);
`else
        checkOutput("no err pulses", 32'(err_n), 0);
`endif

        checkOutput("valid gap between txns", 32'(gap_viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udma_extper_cfg_seq.md
Name: udma_extper_cfg_seq

Overview:
- Bus-master sequencer that shares the uDMA external-peripheral channel config port between NREQ requesters.
- Accepts one transfer descriptor per requester: direction, L2 start address, size, datasize.
- Arbitrates round-robin, then issues the SADDR/SIZE/CFG write sequence on the 5-bit cfg bus.
- Polls the channel CFG register until the transfer completes, then pulses done to the winner.

Parameters:
- NREQ, 4, number of requesters (2..8)
- L2_AWIDTH_NOAL, 12, start-address width
- TRANS_SIZE, 16, size-field width
- POLL_GAP, 4, idle cycles between status polls (>=1)
- TIMEOUT_W, 16, timeout counter width (optional feature only)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  NREQ  per-requester descriptor valid
- req_dir_i  in  NREQ  0=RX, 1=TX
- req_addr_i  in  NREQ*L2_AWIDTH_NOAL  packed start addresses; requester i at slice i
- req_size_i  in  NREQ*TRANS_SIZE  packed byte counts
- req_dsize_i  in  NREQ*2  packed datasize codes
- req_ready_o  out  NREQ  one-hot one-cycle grant/accept pulse
- req_done_o  out  NREQ  one-hot one-cycle completion pulse
- req_err_o  out  NREQ  one-hot one-cycle error pulse (timeout only)
- busy_o  out  1  sequence in progress
- cfg_data_o  out  32  write data
- cfg_addr_o  out  5  register word index
- cfg_valid_o  out  1  bus request
- cfg_rwn_o  out  1  1=read, 0=write
- cfg_data_i  in  32  read data, valid when cfg_valid_o & cfg_ready_i & cfg_rwn_o
- cfg_ready_i  in  1  slave accept

Behaviour:
- Reset values: all outputs 0, cfg_rwn_o=0, rr pointer=0, state IDLE. Reset is async, active-high; asserting it mid-sequence aborts immediately with no done/err pulse.
- Register map (word index): RX base 0, TX base 4. Offsets: SADDR +0, SIZE +1, CFG +2.
- CFG read format: bit5=pending, bit4=en.
- IDLE:
  - Round-robin pick among req_valid_i, starting at rr pointer.
  - Grant: latch descriptor, pulse req_ready_o[g], set rr = g+1 mod NREQ, go to WR_SADDR.
  - The grant cycle issues no bus request.
- WR_SADDR: write zero-extended addr to base+0.
- WR_SIZE: write zero-extended size to base+1.
- WR_CFG: write {bit4=1, bits2:1=dsize, bit0=0} to base+2. Continuous mode is never set.
- Bus handshake in all bus states:
  - cfg_valid_o, addr, data and rwn stay stable until cfg_ready_i=1.
  - Transfer completes on the valid&ready cycle; the next state is entered the following cycle.
  - cfg_valid_o is deasserted for at least one cycle between transactions.
- GAP: wait POLL_GAP cycles (counter), then go to POLL.
- POLL: read base+2.
  - If bit4=0 and bit5=0: go to DONE.
  - Otherwise: return to GAP.
- DONE: pulse req_done_o[g] for 1 cycle, go to IDLE. The next grant can occur the cycle after DONE.
- busy_o=1 in every state except IDLE.
- Edge cases:
  - Requester deasserting req_valid_i before its grant: nothing is latched.
  - Descriptor inputs after grant are ignored.
  - req_valid_i held high after done is treated as a new request.
  - Size 0 is sequenced normally: the write occurs, then completion on the first poll that shows idle.
  - Simultaneous requests are granted strictly round-robin. With no requests the rr pointer is unchanged.
  - First poll starts >=POLL_GAP cycles after the CFG write, so the en pulse has reached the channel.

Optional Feature:
- Macro: UDMA_EXTPER_SEQ_TIMEOUT_EN.
- When defined:
  - A TIMEOUT_W counter clears on WR_CFG completion and increments every cycle in GAP/POLL.
  - On saturation (all ones) the sequence leaves GAP/POLL: if in POLL, the outstanding read handshake completes first; no further polls are issued.
  - It then writes base+2 with bit5=1 (clr) and pulses req_err_o[g] instead of req_done_o[g], then returns to IDLE.
- When undefined: no counter, req_err_o tied 0, polling is unbounded.

Test Plan:
- Single RX request, requester 0, addr=0x123, size=0x40, dsize=2, cfg_ready_i=1, status reads en=1 twice then 0 -> writes (0,0x123), (1,0x40), (2,0x14); three reads of addr 2; one req_done_o[0] pulse; busy_o low afterwards.
- TX request from requester 2 -> addresses 4, 5, 6 used; CFG data 0x10|dsize<<1.
- All 4 requesters valid continuously from reset -> grant order 0, 1, 2, 3, 0; each grant followed by exactly one done before the next grant.
- cfg_ready_i low for 3 cycles on the SIZE write -> cfg_addr_o=1 and cfg_data_o held stable for 4 cycles; no write skipped or duplicated.
- rst_i asserted during GAP -> next cycle all outputs 0, no done pulse; a new request is served from WR_SADDR.
- With UDMA_EXTPER_SEQ_TIMEOUT_EN, TIMEOUT_W=4, status stuck at en=1 -> clr write (addr 2, data 0x20), req_err_o pulse, no req_done_o.
